// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with writeback bypass, load-use bubble insertion,
// flush/hold priority control and a saturating bubble counter.
module id_ex_hazard_stage #(
    parameter int XLEN   = 32,
    parameter int PC_W   = 16,
    parameter int CTRL_W = 16,  // must be >= 3: bit2 marks a load
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_D,
    input  logic [CTRL_W-1:0] ctrl_D,
    input  logic [4:0]        rs1_D,
    input  logic [4:0]        rs2_D,
    input  logic [4:0]        rd_D,
    input  logic [XLEN-1:0]   rd1_D,
    input  logic [XLEN-1:0]   rd2_D,
    input  logic [XLEN-1:0]   imm_D,
    input  logic [PC_W-1:0]   pc_D,
    input  logic [PC_W-1:0]   pc_plus4_D,
    input  logic              reg_we_W,
    input  logic [4:0]        rd_W,
    input  logic [XLEN-1:0]   wd_W,
    input  logic              stall_ext,
    input  logic              flush_E,
    output logic              valid_E,
    output logic [CTRL_W-1:0] ctrl_E,
    output logic [4:0]        rs1_E,
    output logic [4:0]        rs2_E,
    output logic [4:0]        rd_E,
    output logic [XLEN-1:0]   rd1_E,
    output logic [XLEN-1:0]   rd2_E,
    output logic [XLEN-1:0]   imm_E,
    output logic [PC_W-1:0]   pc_E,
    output logic [PC_W-1:0]   pc_plus4_E,
    output logic              pc_write_en,
    output logic              ifid_write_en,
    output logic              ifid_flush,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_HOLD   = 2'd2,
        ACT_FLUSH  = 2'd3
    } act_t;

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_rd1;
    logic [XLEN-1:0]   r_rd2;
    logic [XLEN-1:0]   r_imm;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_pc4;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_hz;
    logic              w_byp1;
    logic              w_byp2;
    logic [XLEN-1:0]   w_rd1;
    logic [XLEN-1:0]   w_rd2;
    logic              w_cnt_sat;
    act_t              w_act;

    // Hazard looks only at the E-stage load; a simultaneous writeback to the
    // same register does not help because the load result is not yet known.
    assign w_hz = r_valid && r_ctrl[2] && valid_D && (r_rd != 5'd0) &&
                  ((r_rd == rs1_D) || (r_rd == rs2_D));

    assign w_byp1 = reg_we_W && (rd_W != 5'd0) && (rd_W == rs1_D);
    assign w_byp2 = reg_we_W && (rd_W != 5'd0) && (rd_W == rs2_D);
    assign w_rd1  = w_byp1 ? wd_W : rd1_D;
    assign w_rd2  = w_byp2 ? wd_W : rd2_D;

    assign w_cnt_sat = (r_cnt == {CNT_W{1'b1}});

    always_comb begin
        w_act = ACT_LOAD;
        if (flush_E)        w_act = ACT_FLUSH;
        else if (stall_ext) w_act = ACT_HOLD;
        else if (w_hz)      w_act = ACT_BUBBLE;
    end

    // Front-end controls; reset forces the free-running LOAD view.
    always_comb begin
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        ifid_flush    = 1'b0;
        if (!reset) begin
            case (w_act)
                ACT_FLUSH:  ifid_flush = 1'b1;
                ACT_HOLD,
                ACT_BUBBLE: begin
                    pc_write_en   = 1'b0;
                    ifid_write_en = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_pc    <= '0;
            r_pc4   <= '0;
            r_cnt   <= '0;
        end else begin
            case (w_act)
                ACT_FLUSH, ACT_BUBBLE: begin
                    r_valid <= 1'b0;
                    r_ctrl  <= '0;
                    r_rs1   <= '0;
                    r_rs2   <= '0;
                    r_rd    <= '0;
                    r_rd1   <= '0;
                    r_rd2   <= '0;
                    r_imm   <= '0;
                    r_pc    <= '0;
                    r_pc4   <= '0;
                    if (w_act == ACT_BUBBLE && !w_cnt_sat)
                        r_cnt <= r_cnt + 1'b1;
                end
                ACT_LOAD: begin
                    r_valid <= valid_D;
                    r_ctrl  <= ctrl_D;
                    r_rs1   <= rs1_D;
                    r_rs2   <= rs2_D;
                    r_rd    <= rd_D;
                    r_rd1   <= w_rd1;
                    r_rd2   <= w_rd2;
                    r_imm   <= imm_D;
                    r_pc    <= pc_D;
                    r_pc4   <= pc_plus4_D;
                end
                default: ;  // HOLD keeps everything
            endcase
        end
    end

    assign valid_E    = r_valid;
    assign ctrl_E     = r_ctrl;
    assign rs1_E      = r_rs1;
    assign rs2_E      = r_rs2;
    assign rd_E       = r_rd;
    assign rd1_E      = r_rd1;
    assign rd2_E      = r_rd2;
    assign imm_E      = r_imm;
    assign pc_E       = r_pc;
    assign pc_plus4_E = r_pc4;
    assign bubble_cnt = r_cnt;

endmodule
